// File: rtl/fetch_decode_queue.sv
// Instruction queue between Fetch and Decode: in-order {inst, PC} buffer with
// valid/ready on both sides, flush on taken branch/jump, and NOP when empty.
module fetch_decode_queue #(
  parameter int DEPTH = 4,
  parameter int PTR_W = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_inst,
  input  logic [31:0]      in_pc,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_inst,
  output logic [31:0]      out_pc,
  output logic [31:0]      out_pc_plus4,
  output logic [PTR_W:0]   count
);

  localparam logic [PTR_W:0]   FULL_CNT = (PTR_W+1)'(DEPTH);
  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
  localparam logic [PTR_W:0]   CNT_ONE  = (PTR_W+1)'(1);

  // Each entry keeps {inst, pc} together so they can never drift apart.
  logic [63:0]      mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             push;
  logic             pop;
  logic [63:0]      head;

  assign in_ready  = (count != FULL_CNT);
  assign out_valid = (count != '0);
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;

  // Data storage carries no reset; stale words are masked by out_valid.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= {in_inst, in_pc};
    end
  end

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
      case ({push, pop})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
    end
  end

  assign head = mem[rd_ptr];

  always_comb begin
    out_inst     = 32'h0;
    out_pc       = 32'h0;
    out_pc_plus4 = 32'h0;
    if (out_valid) begin
      out_inst     = head[63:32];
      out_pc       = head[31:0];
      out_pc_plus4 = head[31:0] + 32'd4;
    end
  end

endmodule

// File: tb/tb_fetch_decode_queue.sv
// Randomized and directed bench for fetch_decode_queue against a queue-based
// reference model of the in-order instruction buffer.
module tb_fetch_decode_queue;

  localparam int DEPTH = 4;
  localparam int PTR_W = 2;

  logic             clk;
  logic             reset;
  logic             flush;
  logic             in_valid;
  logic             in_ready;
  logic [31:0]      in_inst;
  logic [31:0]      in_pc;
  logic             out_valid;
  logic             out_ready;
  logic [31:0]      out_inst;
  logic [31:0]      out_pc;
  logic [31:0]      out_pc_plus4;
  logic [PTR_W:0]   count;

  int errs;
  int checks;

  logic [63:0] model_q[$];

  fetch_decode_queue #(.DEPTH(DEPTH), .PTR_W(PTR_W)) dut (
    .clk          (clk),
    .reset        (reset),
    .flush        (flush),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_inst      (in_inst),
    .in_pc        (in_pc),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_inst     (out_inst),
    .out_pc       (out_pc),
    .out_pc_plus4 (out_pc_plus4),
    .count        (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs(input string ctx);
    logic [31:0] e_inst, e_pc, e_pc4;
    int n;
    n = model_q.size();
    e_inst = 32'h0;
    e_pc   = 32'h0;
    e_pc4  = 32'h0;
    if (n > 0) begin
      e_inst = model_q[0][63:32];
      e_pc   = model_q[0][31:0];
      e_pc4  = e_pc + 32'd4;
    end
    check({ctx, ".count"},     32'(count),     32'(n));
    check({ctx, ".out_valid"}, 32'(out_valid), (n > 0) ? 32'd1 : 32'd0);
    check({ctx, ".in_ready"},  32'(in_ready),  (n < DEPTH) ? 32'd1 : 32'd0);
    check({ctx, ".out_inst"},  out_inst,       e_inst);
    check({ctx, ".out_pc"},    out_pc,         e_pc);
    check({ctx, ".out_pc4"},   out_pc_plus4,   e_pc4);
  endtask

  // One clock cycle: check current outputs, drive inputs, advance model.
  task automatic cycle(input string ctx, input logic rst, input logic fl,
                       input logic iv, input logic [31:0] ii, input logic [31:0] ip,
                       input logic ordy);
    bit do_push, do_pop;
    @(negedge clk);
    check_outputs(ctx);
    reset     = rst;
    flush     = fl;
    in_valid  = iv;
    in_inst   = ii;
    in_pc     = ip;
    out_ready = ordy;
    @(posedge clk);
    if (rst || fl) begin
      model_q.delete();
    end else begin
      do_push = iv && (model_q.size() < DEPTH);
      do_pop  = ordy && (model_q.size() > 0);
      if (do_pop)  void'(model_q.pop_front());
      if (do_push) model_q.push_back({ii, ip});
    end
  endtask

  initial begin
    logic [31:0] pc;
    errs      = 0;
    checks    = 0;
    reset     = 1'b1;
    flush     = 1'b0;
    in_valid  = 1'b0;
    in_inst   = 32'h0;
    in_pc     = 32'h0;
    out_ready = 1'b0;
    repeat (2) @(posedge clk);
    model_q.delete();

    // Release reset, then fill to full and try a fifth push.
    cycle("rst", 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
    for (int i = 0; i < 5; i++)
      cycle("fill", 1'b0, 1'b0, 1'b1, 32'h20080001 + 32'(i), 32'(4 * i), 1'b0);
    cycle("full", 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);

    // Drain in order, then observe the empty NOP.
    for (int i = 0; i < 5; i++)
      cycle("drain", 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1);

    // Hold at two entries with simultaneous push/pop across pointer wrap.
    cycle("pp_fill", 1'b0, 1'b0, 1'b1, 32'hA0000000, 32'h100, 1'b0);
    cycle("pp_fill", 1'b0, 1'b0, 1'b1, 32'hA0000001, 32'h104, 1'b0);
    for (int i = 0; i < 10; i++)
      cycle("pushpop", 1'b0, 1'b0, 1'b1, 32'hA0000002 + 32'(i), 32'h108 + 32'(4 * i), 1'b1);

    // Bring to three entries, then flush with an incoming instruction.
    cycle("fl_fill", 1'b0, 1'b0, 1'b1, 32'hB0000000, 32'h200, 1'b0);
    cycle("fl_pre",  1'b0, 1'b1, 1'b1, 32'hDEADBEEF, 32'h204, 1'b1);
    cycle("fl_post", 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);

    // PC wraparound on out_pc_plus4, then reset with two entries queued.
    cycle("wrap", 1'b0, 1'b0, 1'b1, 32'h12345678, 32'hFFFFFFFC, 1'b0);
    cycle("wrap", 1'b0, 1'b0, 1'b1, 32'h12345679, 32'h00000000, 1'b0);
    cycle("rst2", 1'b1, 1'b0, 1'b1, 32'h55555555, 32'h300, 1'b1);
    cycle("rst2_post", 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);

    // Randomized traffic with occasional flush and reset.
    pc = 32'h0;
    for (int i = 0; i < 2000; i++) begin
      logic r, f, v, o;
      r = ($urandom_range(0, 99) == 0);
      f = ($urandom_range(0, 19) == 0);
      v = ($urandom_range(0, 9) < 6);
      o = ($urandom_range(0, 9) < 5);
      if ($urandom_range(0, 49) == 0) pc = 32'hFFFFFFF8 + 32'(4 * $urandom_range(0, 1));
      else pc = pc + 32'd4;
      cycle("rand", r, f, v, $urandom(), pc, o);
    end

    @(negedge clk);
    check_outputs("final");
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
